// File: rtl/seg7_scan_display.sv
// Six-digit multiplexed 7-segment driver with frame-coherent digit capture, dead-time and blink.
// Latency: one cycle from the scan position to seg/dig_sel. There is no backpressure; scanning is free-running.
module seg7_scan_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       load,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       frame_tick,
  output logic       blank_phase
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            blank_q, blank_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      dig_q, dig_d;
  logic            tick_q, tick_d;
  logic            slot_end, frame_end;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hE: decode = 7'h79;
      4'hF: decode = 7'h00;
      default: decode = 7'h40;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == 3'd5);

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    fcnt_d   = fcnt_q;
    blank_d  = blank_q;
    if (slot_end) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    // Digits are sampled only at the frame edge so a frame never mixes old and new codes.
    if (frame_end) begin
      if (load) begin
        shadow_d = {d6, d5, d4, d3, d2, d1};
      end
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blank_d = ~blank_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    seg_d  = decode(shadow_q[idx_q]);
    dig_d  = ((cnt_q >= CW'(DEAD)) && !(blink_en && blank_q)) ? (6'd1 << idx_q) : 6'd0;
    tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      fcnt_q   <= '0;
      blank_q  <= 1'b0;
      seg_q    <= '0;
      dig_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      fcnt_q   <= fcnt_d;
      blank_q  <= blank_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_q;
  assign frame_tick  = tick_q;
  assign blank_phase = blank_q;
endmodule
